// File: rtl/wb_pkg.sv
// Writeback shared types: source request payload, default sizing, source indices.
// No logic; pure declarations.
// No flow control.
package wb_pkg;

    localparam int WB_NUM_SRC    = 3;
    localparam int WB_DATA_W     = 32;
    localparam int WB_ADDR_W     = 5;
    localparam int WB_HOLD_DEPTH = 2;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MEM = 1;
    localparam int WB_SRC_MUL = 2;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source hold FIFO; exposes every slot's valid/addr for the hazard check.
// Latency: push visible at head one edge later; no fall-through.
// Backpressure: pushes while full are dropped, caller gates on count.
module wb_src_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH  = WB_HOLD_DEPTH,
    parameter int  ADDR_W = WB_ADDR_W,
    parameter type req_t  = wb_req_t,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                           clock,
    input  logic                           reset_c,
    input  logic                           push_vld,
    input  req_t                           push_dat,
    input  logic                           pop,
    output req_t                           head_dat,
    output logic                           empty,
    output logic [CNT_W-1:0]               count,
    output logic [DEPTH-1:0]               ent_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr
);

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Push and pop can never target the same slot: that needs full and empty at once.
    always_ff @(posedge clock) begin
        if (reset_c) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (do_push) begin
                wr_ptr          <= ptr_inc(wr_ptr);
                ent_vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr          <= ptr_inc(rd_ptr);
                ent_vld[rd_ptr] <= 1'b0;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_addr[j] = mem[j].addr;
        end
    end

endmodule

// File: rtl/wb_multi_src.sv
// Writeback merge: NUM_SRC producers -> round-robin -> one registered RF write port.
// Latency: 2 edges push-to-writeEn uncontended; NUM_SRC*HOLD_DEPTH+1 worst case.
// Backpressure: src_ready per source from registered FIFO count; stall_wb freezes pop and outputs.
module wb_multi_src
    import wb_pkg::*;
#(
    parameter int NUM_SRC    = WB_NUM_SRC,
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int HOLD_DEPTH = WB_HOLD_DEPTH,
    parameter bit DROP_R0    = 1'b1
) (
    input  logic                            clock,
    input  logic                            reset_c,
    input  logic                            stall_wb,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data,
    input  logic [NUM_SRC-1:0][ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]               chk_addr,
    output logic                            chk_pending,
    output logic [DATA_W-1:0]               wbOut,
    output logic [ADDR_W-1:0]               wbOutAddr,
    output logic                            writeEn
);

    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(HOLD_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } src_req_t;

    src_req_t                                    push_req [NUM_SRC];
    src_req_t                                    head     [NUM_SRC];
    logic [NUM_SRC-1:0]                          push;
    logic [NUM_SRC-1:0]                          pop;
    logic [NUM_SRC-1:0]                          empty;
    logic [NUM_SRC-1:0][CNT_W-1:0]               count;
    logic [NUM_SRC-1:0][HOLD_DEPTH-1:0]          ent_vld;
    logic [NUM_SRC-1:0][HOLD_DEPTH-1:0][ADDR_W-1:0] ent_addr;

    logic [RR_W-1:0] rr_ptr;
    logic [RR_W-1:0] rr_next;
    logic [RR_W-1:0] grant;
    logic            grant_vld;
    src_req_t        gnt_req;
    logic            pend_hit;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
        assign src_ready[g] = !reset_c && (count[g] < CNT_W'(HOLD_DEPTH));
        assign push[g]      = src_valid[g] && src_ready[g];
        assign push_req[g]  = '{addr: src_addr[g], data: src_data[g]};

        wb_src_fifo #(
            .DEPTH  (HOLD_DEPTH),
            .ADDR_W (ADDR_W),
            .req_t  (src_req_t)
        ) u_fifo (
            .clock    (clock),
            .reset_c  (reset_c),
            .push_vld (push[g]),
            .push_dat (push_req[g]),
            .pop      (pop[g]),
            .head_dat (head[g]),
            .empty    (empty[g]),
            .count    (count[g]),
            .ent_vld  (ent_vld[g]),
            .ent_addr (ent_addr[g])
        );
    end

    // First non-empty source at or after the round-robin pointer.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant     = RR_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (!stall_wb && grant_vld) begin
            pop[grant] = 1'b1;
        end
    end

    assign gnt_req = head[grant];
    assign rr_next = (grant == RR_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clock) begin
        if (reset_c) begin
            wbOut     <= '0;
            wbOutAddr <= '0;
            writeEn   <= 1'b0;
            rr_ptr    <= '0;
        end else if (!stall_wb) begin
            if (grant_vld) begin
                wbOut     <= gnt_req.data;
                wbOutAddr <= gnt_req.addr;
                writeEn   <= !(DROP_R0 && (gnt_req.addr == '0));
                rr_ptr    <= rr_next;
            end else begin
                writeEn   <= 1'b0;
            end
        end
    end

    always_comb begin
        pend_hit = writeEn && (wbOutAddr == chk_addr);
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < HOLD_DEPTH; j++) begin
                if (ent_vld[i][j] && (ent_addr[i][j] == chk_addr)) begin
                    pend_hit = 1'b1;
                end
            end
        end
    end

    // r0 writes are discarded, so they never create a hazard.
    assign chk_pending = pend_hit && !(DROP_R0 && (chk_addr == '0));

endmodule
